cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
Parameters: none. Opcode encoding and phase count are fixed by REQ-012 and REQ-013.
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port `opcode`: input, 3 bits, the instruction register upper bits [7:5]; valid from phase 3 onward.
REQ-005 SHALL have port `zero`: input, 1 bit, the accumulator-is-zero flag from the datapath.
REQ-006 SHALL have port `step`: input, 1 bit, the single-step advance pulse; present only when CTRL_SINGLE_STEP_EN is defined.
REQ-007 SHALL have output ports `sel`, `rd`, `ld_ir`, `inc_pc`, `ld_pc`, `ld_ac`, `wr`, `data_e`, `halt`, 1 bit each, as datapath control strobes.
REQ-008 SHALL have port `phase`: output, 3 bits, the current phase number.
REQ-009 SHALL have port `instr_done`: output, 1 bit, high for the single cycle of phase 7.

Function
REQ-010 SHALL hold a 3-bit phase counter that advances 0->1->...->7->0 once per clock when not halted or stalled.
REQ-011 SHALL drive all strobes combinationally from the registered phase, `opcode` and `zero`; zero cycles of added latency.
REQ-012 SHALL decode opcodes as HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-013 SHALL define ALUOP as opcode in {ADD, AND, XOR, LDA}.
REQ-014 SHALL produce these strobes per phase; unlisted strobes are 0:
- phase 0: sel.
- phase 1: sel, rd.
- phase 2: sel, rd, ld_ir.
- phase 3: sel, rd, ld_ir.
- phase 4: inc_pc; halt if HLT.
- phase 5: rd if ALUOP.
- phase 6: rd if ALUOP; inc_pc if SKZ and zero; ld_pc if JMP; data_e if STO.
- phase 7: rd and ld_ac if ALUOP; ld_pc if JMP; wr and data_e if STO.
REQ-015 SHALL set an internal halted flag at the end of phase 4 when opcode=HLT, and freeze `phase` at 4.
REQ-016 SHALL, while halted, hold `halt`=1 and all other strobes and `instr_done` at 0, until `rst`.
REQ-017 SHALL sample `zero` only in phase 6; `zero` in other phases has no effect.
REQ-018 SHALL never assert `wr` and `rd` in the same cycle, nor `ld_pc` and `inc_pc` in the same cycle, for any opcode.
REQ-019 SHALL follow the phase 7 -> 0 wrap immediately with the next fetch; there are no idle cycles between instructions.

Reset
REQ-020 SHALL, on `rst`=1 at a clock edge, set phase=0, clear halted, and clear the step-pending register.
REQ-021 SHALL give reset priority over `step`, halt entry and phase advance, including when reset arrives mid-instruction.
REQ-022 SHALL, in the reset cycle's following state, present phase 0 outputs: sel=1, all else 0.

Configuration
REQ-023 SHALL support the macro CTRL_SINGLE_STEP_EN:
- Defined: port `step` exists, with a 1-bit step-pending register set by `step`=1.
- Phase 0 advances to 1 only in a cycle where `step`=1 or pending=1; that advance clears pending.
- Other phases advance freely.
- A `step` pulse arriving while in phases 1-7 is remembered for the next phase 0.
REQ-024 SHALL, with CTRL_SINGLE_STEP_EN undefined, omit `step` and the pending register, and let phase 0 always advance.

Verification
REQ-025 SHALL cover reset: `rst`=1 for 2 cycles mid-phase 5 -> phase=0, sel=1, halt=0 on the following cycle.
REQ-026 SHALL cover STO: opcode=6 -> data_e=1 in phases 6-7, wr=1 only in phase 7, rd=0 in phases 5-7.
REQ-027 SHALL cover SKZ: opcode=1 with zero=1 -> inc_pc=1 in phases 4 and 6; with zero=0 -> inc_pc=1 in phase 4 only.
REQ-028 SHALL cover JMP: opcode=7 -> ld_pc=1 in phases 6-7; phase wraps 7->0 with instr_done=1 in phase 7.
REQ-029 SHALL cover HLT: opcode=0 -> halt=1 from phase 4; phase stays 4 for 20 cycles with all other strobes 0; `rst` then restores phase 0.
REQ-030 SHALL cover single step with CTRL_SINGLE_STEP_EN: no `step` -> phase held at 0 for 10 cycles; a 1-cycle `step` -> one full 8-phase instruction, then hold at 0 again.

Source files
------------

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module  : cpu_controller
// Brief   : 8-phase instruction sequencer for the accumulator CPU; decodes the
//           opcode into datapath strobes. Optional CTRL_SINGLE_STEP_EN adds a
//           step input that gates the fetch phase.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase,
    output logic       instr_done
);

    localparam logic [2:0] c_OP_HLT = 3'd0;
    localparam logic [2:0] c_OP_SKZ = 3'd1;
    localparam logic [2:0] c_OP_ADD = 3'd2;
    localparam logic [2:0] c_OP_LDA = 3'd5;
    localparam logic [2:0] c_OP_STO = 3'd6;
    localparam logic [2:0] c_OP_JMP = 3'd7;

    localparam logic [2:0] c_PH0 = 3'd0;
    localparam logic [2:0] c_PH1 = 3'd1;
    localparam logic [2:0] c_PH2 = 3'd2;
    localparam logic [2:0] c_PH3 = 3'd3;
    localparam logic [2:0] c_PH4 = 3'd4;
    localparam logic [2:0] c_PH5 = 3'd5;
    localparam logic [2:0] c_PH6 = 3'd6;
    localparam logic [2:0] c_PH7 = 3'd7;

    logic [2:0] r_phase;
    logic       r_halted;
    logic       w_aluop;
    logic       w_hlt_enter;
    logic       w_advance;

    // ADD, AND, XOR and LDA are contiguous encodings 2..5
    assign w_aluop     = (opcode >= c_OP_ADD) && (opcode <= c_OP_LDA);
    assign w_hlt_enter = (r_phase == c_PH4) && (opcode == c_OP_HLT);

`ifdef CTRL_SINGLE_STEP_EN
    logic r_step_pending;

    assign w_advance = (r_phase != c_PH0) || step || r_step_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_pending <= 1'b0;
        end else if ((r_phase == c_PH0) && !r_halted && w_advance) begin
            r_step_pending <= 1'b0;
        end else if (step) begin
            r_step_pending <= 1'b1;
        end
    end
`else
    assign w_advance = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= c_PH0;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (w_hlt_enter) begin
                r_halted <= 1'b1;
            end else if (w_advance) begin
                r_phase <= r_phase + 3'd1;
            end
        end
    end

    assign phase = r_phase;

    always_comb begin
        sel        = 1'b0;
        rd         = 1'b0;
        ld_ir      = 1'b0;
        inc_pc     = 1'b0;
        ld_pc      = 1'b0;
        ld_ac      = 1'b0;
        wr         = 1'b0;
        data_e     = 1'b0;
        halt       = 1'b0;
        instr_done = 1'b0;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            case (r_phase)
                c_PH0: begin
                    sel = 1'b1;
                end
                c_PH1: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                c_PH2, c_PH3: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                c_PH4: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == c_OP_HLT);
                end
                c_PH5: begin
                    rd = w_aluop;
                end
                c_PH6: begin
                    // zero only matters here, where SKZ decides to skip
                    rd     = w_aluop;
                    inc_pc = (opcode == c_OP_SKZ) && zero;
                    ld_pc  = (opcode == c_OP_JMP);
                    data_e = (opcode == c_OP_STO);
                end
                c_PH7: begin
                    rd         = w_aluop;
                    ld_ac      = w_aluop;
                    ld_pc      = (opcode == c_OP_JMP);
                    wr         = (opcode == c_OP_STO);
                    data_e     = (opcode == c_OP_STO);
                    instr_done = 1'b1;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_controller
// Brief   : Directed scoreboard bench for cpu_controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, instr_done;
    logic [2:0] phase;
`ifdef CTRL_SINGLE_STEP_EN
    logic       step = 1'b1;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [12:0] q[$];

    cpu_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
`ifdef CTRL_SINGLE_STEP_EN
        .step       (step),
`endif
        .sel        (sel),
        .rd         (rd),
        .ld_ir      (ld_ir),
        .inc_pc     (inc_pc),
        .ld_pc      (ld_pc),
        .ld_ac      (ld_ac),
        .wr         (wr),
        .data_e     (data_e),
        .halt       (halt),
        .phase      (phase),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    wire [12:0] w_obs = {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, instr_done};

    // Expected vector {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, instr_done}
    function automatic logic [12:0] model(input int p, input logic [2:0] op,
                                          input logic z, input logic hl);
        logic alu, e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt, e_done;
        logic [2:0] ph;
        if (hl) return {3'd4, 10'b00_0000_0010};
        alu    = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        ph     = p[2:0];
        e_sel  = (p <= 3);
        e_rd   = (p >= 1 && p <= 3) || (p >= 5 && alu);
        e_ldir = (p == 2) || (p == 3);
        e_inc  = (p == 4) || (p == 6 && op == 3'd1 && z);
        e_ldpc = (p >= 6) && (op == 3'd7);
        e_ldac = (p == 7) && alu;
        e_wr   = (p == 7) && (op == 3'd6);
        e_de   = (p >= 6) && (op == 3'd6);
        e_halt = (p == 4) && (op == 3'd0);
        e_done = (p == 7);
        return {ph, e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt, e_done};
    endfunction

    task automatic run_phase(input string tag, input int p, input logic [2:0] op,
                             input logic z, input logic hl);
        logic [12:0] exp;
        opcode = op;
        zero   = z;
        q.push_back(model(p, op, z, hl));
        @(negedge clk);
        exp = q.pop_front();
        n_total++;
        assert (w_obs === exp) n_pass++;
        else $error("FAIL %s ph%0d: observed %b expected %b", tag, p, w_obs, exp);
        n_total++;
        assert (!(rd && wr) && !(ld_pc && inc_pc)) n_pass++;
        else $error("FAIL %s_excl ph%0d: observed rd/wr/ld_pc/inc_pc=%b%b%b%b expected no overlap",
                    tag, p, rd, wr, ld_pc, inc_pc);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [2:0] op, input logic [7:0] zmask);
        for (int p = 0; p < 8; p++) run_phase(tag, p, op, zmask[p], 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset(2);
        run_instr("add",      3'd2, 8'h00);
        run_instr("and",      3'd3, 8'hFF);
        run_instr("xor",      3'd4, 8'h00);
        run_instr("lda",      3'd5, 8'h40);
        run_instr("sto",      3'd6, 8'h00);
        run_instr("skz_z1",   3'd1, 8'hFF);
        run_instr("skz_z0",   3'd1, 8'h00);
        // zero high everywhere except the sampling phase must not skip
        run_instr("skz_mask", 3'd1, 8'hBF);
        run_instr("jmp",      3'd7, 8'h00);
        run_phase("wrap", 0, 3'd2, 1'b0, 1'b0);

        // reset arriving in phase 5, held two edges
        for (int p = 1; p < 5; p++) run_phase("pre_rst", p, 3'd2, 1'b0, 1'b0);
        rst = 1'b1;
        run_phase("pre_rst", 5, 3'd2, 1'b0, 1'b0);
        run_phase("in_rst", 0, 3'd2, 1'b0, 1'b0);
        rst = 1'b0;
        run_instr("post_rst", 3'd6, 8'h00);

        // halt entry and hold
        for (int p = 0; p < 5; p++) run_phase("hlt", p, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) run_phase("halted", 4, 3'd0, i[0], 1'b1);
        do_reset(1);
        run_instr("after_hlt", 3'd7, 8'h00);

`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b0;
        do_reset(1);
        for (int i = 0; i < 10; i++) run_phase("ss_hold", 0, 3'd2, 1'b0, 1'b0);
        step = 1'b1;
        run_phase("ss_step", 0, 3'd2, 1'b0, 1'b0);
        step = 1'b0;
        for (int p = 1; p < 8; p++) run_phase("ss_run", p, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run_phase("ss_hold2", 0, 3'd2, 1'b0, 1'b0);
        step = 1'b1;
        run_phase("ss_step2", 0, 3'd2, 1'b0, 1'b0);
        step = 1'b0;
        run_phase("ss_run2", 1, 3'd2, 1'b0, 1'b0);
        step = 1'b1;
        run_phase("ss_run2", 2, 3'd2, 1'b0, 1'b0);
        step = 1'b0;
        for (int p = 3; p < 8; p++) run_phase("ss_run2", p, 3'd2, 1'b0, 1'b0);
        run_instr("ss_pending", 3'd2, 8'h00);
        run_phase("ss_hold3", 0, 3'd2, 1'b0, 1'b0);
        run_phase("ss_hold3", 0, 3'd2, 1'b0, 1'b0);
        step = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
